// File: rtl/gmii_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gmii_rx_frame
// Description : GMII receive framer. Strips preamble/SFD, checks CRC-32 and
//               removes the FCS, emitting a marked byte stream with per-frame
//               status. Optional length check via GMII_RX_LEN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        gmii_rx_clk,
    input  logic        reset_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_good,
    output logic [15:0] rx_frame_len,
    output logic [15:0] rx_drop_cnt
);

    typedef enum logic [2:0] {
        WAIT_GAP = 3'd0,
        IDLE     = 3'd1,
        PREAMBLE = 3'd2,
        DATA     = 3'd3,
        DROP     = 3'd4
    } state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    state_t          state;
    state_t          state_next;
    logic            pre_load;
    logic            pre_inc;
    logic            sfd;
    logic            shift;
    logic            close;
    logic            drop_inc;

    logic [2:0]      pre_cnt;
    logic [4:0][7:0] dline;
    logic [2:0]      fill;
    logic [31:0]     crc;
    logic [15:0]     len;
    logic            err;
    logic            sof_pend;

    logic            full;
    logic            crc_ok;
    logic            len_ok;
    logic            frame_ok;
    logic [31:0]     crc_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign crc_next = crc_byte(crc, gmii_rxd);
    assign full     = (fill == 3'd5);
    assign crc_ok   = (crc == CRC_RESIDUE);

`ifdef GMII_RX_LEN_CHECK_EN
    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);
    // A saturated counter means the true length is unknown and too long.
    assign len_ok = (len >= MIN_L) && (len <= MAX_L) && (len != 16'hFFFF);
`else
    assign len_ok = 1'b1;
`endif

    assign frame_ok = crc_ok && !err && len_ok;

    always_ff @(posedge gmii_rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_GAP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pre_load   = 1'b0;
        pre_inc    = 1'b0;
        sfd        = 1'b0;
        shift      = 1'b0;
        close      = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            WAIT_GAP: begin
                if (!gmii_rx_dv) state_next = IDLE;
            end
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == 8'h55) begin
                        state_next = PREAMBLE;
                        pre_load   = 1'b1;
                    end else begin
                        state_next = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_next = IDLE;
                    drop_inc   = 1'b1;
                end else if (gmii_rx_er) begin
                    state_next = DROP;
                end else if (gmii_rxd == 8'hD5) begin
                    state_next = DATA;
                    sfd        = 1'b1;
                end else if (gmii_rxd == 8'h55 && pre_cnt != 3'd7) begin
                    pre_inc = 1'b1;
                end else begin
                    state_next = DROP;
                end
            end
            DATA: begin
                if (gmii_rx_dv) begin
                    shift = 1'b1;
                end else begin
                    close      = 1'b1;
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (!gmii_rx_dv) begin
                    state_next = IDLE;
                    drop_inc   = 1'b1;
                end
            end
            default: state_next = WAIT_GAP;
        endcase
    end

    always_ff @(posedge gmii_rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt      <= 3'd0;
            dline        <= '0;
            fill         <= 3'd0;
            crc          <= CRC_INIT;
            len          <= 16'd0;
            err          <= 1'b0;
            sof_pend     <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_sof       <= 1'b0;
            rx_eof       <= 1'b0;
            rx_good      <= 1'b0;
            rx_frame_len <= 16'd0;
            rx_drop_cnt  <= 16'd0;
        end else begin
            rx_valid     <= 1'b0;
            rx_sof       <= 1'b0;
            rx_eof       <= 1'b0;
            rx_good      <= 1'b0;
            rx_frame_len <= 16'd0;

            if (pre_load) begin
                pre_cnt <= 3'd1;
            end else if (pre_inc) begin
                pre_cnt <= pre_cnt + 3'd1;
            end

            if (sfd) begin
                dline    <= '0;
                fill     <= 3'd0;
                crc      <= CRC_INIT;
                len      <= 16'd0;
                err      <= 1'b0;
                sof_pend <= 1'b1;
            end

            if (shift) begin
                dline <= {dline[3:0], gmii_rxd};
                fill  <= full ? 3'd5 : fill + 3'd1;
                crc   <= crc_next;
                if (len != 16'hFFFF) len <= len + 16'd1;
                if (gmii_rx_er) err <= 1'b1;
            end

            // Stage 5 leaves only once four newer bytes sit behind it, so
            // whatever remains in stages 1-4 at the close is the FCS.
            if ((shift || close) && full) begin
                rx_data  <= dline[4];
                rx_valid <= 1'b1;
                rx_sof   <= sof_pend;
                sof_pend <= 1'b0;
                if (close) begin
                    rx_eof       <= 1'b1;
                    rx_good      <= frame_ok;
                    rx_frame_len <= len;
                end
            end

            if ((drop_inc || (close && !full)) && rx_drop_cnt != 16'hFFFF) begin
                rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmii_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gmii_rx_frame
// Description : Self-checking bench for gmii_rx_frame (table of frames plus
//               hand-written preamble, reset and runt sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_rx_frame;

    logic        clk;
    logic        reset_n;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_good;
    logic [15:0] rx_frame_len;
    logic [15:0] rx_drop_cnt;

    gmii_rx_frame #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .gmii_rx_clk  (clk),
        .reset_n      (reset_n),
        .gmii_rxd     (gmii_rxd),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_eof       (rx_eof),
        .rx_good      (rx_good),
        .rx_frame_len (rx_frame_len),
        .rx_drop_cnt  (rx_drop_cnt)
    );

`ifdef GMII_RX_LEN_CHECK_EN
    localparam bit GOOD_SHORT = 1'b0;
    localparam bit GOOD_LONG  = 1'b0;
`else
    localparam bit GOOD_SHORT = 1'b1;
    localparam bit GOOD_LONG  = 1'b1;
`endif

    typedef struct {
        logic [7:0] data;
        bit         sof;
        bit         eof;
        bit         good;
        int         len;
        int         cyc;
    } exp_t;

    typedef struct {
        int len;
        bit flip;
        int er_at;
        bit good;
        int gap;
    } vec_t;

    exp_t q[$];
    exp_t e;
    vec_t vecs[8];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   exp_drop = 0;
    bit   lost;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic drive(input logic [7:0] d, input bit dv, input bit er);
        @(posedge clk);
        #1;
        gmii_rxd   = d;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"},  rx_data,      0);
        chk({tag, "_valid"}, rx_valid,     0);
        chk({tag, "_sof"},   rx_sof,       0);
        chk({tag, "_eof"},   rx_eof,       0);
        chk({tag, "_good"},  rx_good,      0);
        chk({tag, "_len"},   rx_frame_len, 0);
        chk({tag, "_drop"},  rx_drop_cnt,  0);
    endtask

    task automatic send_frame(input int len, input bit flip, input int er_at,
                              input bit good, input int gap);
        logic [7:0]  b[$];
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        if (len >= 5) begin
            for (int i = 0; i < len - 4; i++) begin
                b.push_back(8'($urandom));
                c = crc_upd(c, b[i]);
            end
            c = ~c;
            b.push_back(c[7:0] ^ {7'd0, flip});
            b.push_back(c[15:8]);
            b.push_back(c[23:16]);
            b.push_back(c[31:24]);
        end else begin
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
            drive((i == 7) ? 8'hD5 : 8'h55, 1'b1, 1'b0);
            if (i == 0) chk("drop_cnt", rx_drop_cnt, exp_drop);
        end
        for (int i = 0; i < len; i++) begin
            drive(b[i], 1'b1, i == er_at);
            if (len >= 5 && i < len - 4)
                q.push_back(exp_t'{b[i], i == 0, i == len - 5, good, len, cyc + 6});
        end
        // rx_er during the gap is carrier extension and must not matter
        for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b1);
        if (len < 5) exp_drop++;
    endtask

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                chk("data",    rx_data, e.data);
                chk("sof",     rx_sof,  e.sof);
                chk("eof",     rx_eof,  e.eof);
                chk("latency", cyc,     e.cyc);
                if (e.eof) begin
                    chk("good",      rx_good,      e.good);
                    chk("frame_len", rx_frame_len, e.len);
                end
            end
        end else if (reset_n === 1'b1) begin
            chk("marker_without_valid", rx_sof | rx_eof, 0);
        end
    end

    initial begin
        vecs[0] = '{64,   1'b0, -1, 1'b1,      12};
        vecs[1] = '{64,   1'b1, -1, 1'b0,      12};
        vecs[2] = '{64,   1'b0, 19, 1'b0,      12};
        vecs[3] = '{64,   1'b0, -1, 1'b1,      1};
        vecs[4] = '{64,   1'b0, -1, 1'b1,      12};
        vecs[5] = '{5,    1'b0, -1, GOOD_SHORT, 8};
        vecs[6] = '{3,    1'b0, -1, 1'b0,      8};
        vecs[7] = '{1600, 1'b0, -1, GOOD_LONG, 12};

        reset_n    = 1'b0;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) drive(8'h00, 1'b0, 1'b0);

        foreach (vecs[k]) send_frame(vecs[k].len, vecs[k].flip, vecs[k].er_at,
                                     vecs[k].good, vecs[k].gap);

        // Bad preamble byte
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        repeat (4) drive(8'h00, 1'b0, 1'b0);
        exp_drop++;
        chk("drop_bad_preamble", rx_drop_cnt, exp_drop);

        // Carrier falls during the preamble
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        repeat (4) drive(8'h00, 1'b0, 1'b0);
        exp_drop++;
        chk("drop_short_preamble", rx_drop_cnt, exp_drop);

        // Eight preamble bytes are one too many, even with a valid SFD after
        repeat (8) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        repeat (10) drive(8'hA5, 1'b1, 1'b0);
        repeat (4) drive(8'h00, 1'b0, 1'b0);
        exp_drop++;
        chk("drop_long_preamble", rx_drop_cnt, exp_drop);

        // Reset during byte 30, released while the frame is still on the wire
        lost = 1'b0;
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            drive(8'($urandom), 1'b1, 1'b0);
            if (i == 29) begin
                reset_n = 1'b0;
                q.delete();
                lost     = 1'b1;
                exp_drop = 0;
                #1;
                check_all_zero("midreset");
            end else if (i == 30) begin
                reset_n = 1'b1;
            end
            if (!lost && i < 60)
                q.push_back(exp_t'{gmii_rxd, i == 0, i == 59, 1'b1, 64, cyc + 6});
        end
        repeat (12) drive(8'h00, 1'b0, 1'b0);
        chk("no_partial_output", q.size(), 0);
        send_frame(64, 1'b0, -1, 1'b1, 12);

        for (int i = 0; i < 20 && q.size() != 0; i++) drive(8'h00, 1'b0, 1'b0);
        chk("queue_empty", q.size(), 0);
        chk("drop_final", rx_drop_cnt, exp_drop);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
